lcd_rgb_driver: RTL
===================

# lcd_rgb_driver

Parallel-RGB LCD timing driver: the panel-side end of the pixel interface whose data side is `Lcd_Ge_Data`. It does three things:
- scans horizontal and vertical counters;
- presents `cur_x`/`cur_y` pixel requests to the data generator and accepts its 24-bit colour one cycle later;
- drives registered `lcd_hs`, `lcd_vs`, `lcd_de` and `lcd_rgb`, aligned to the panel.

It sits between the game/data generator and the LCD connector and runs on the pixel clock.

## Interface
Parameters:
- `H_SYNC`, 41: hsync width, pixel clocks
- `H_BACK`, 2: horizontal back porch
- `H_DISP`, 480: active pixels per line (≤ 512)
- `H_FRONT`, 2: horizontal front porch
- `V_SYNC`, 10: vsync width, lines
- `V_BACK`, 2: vertical back porch
- `V_DISP`, 272: active lines (≤ 512)
- `V_FRONT`, 2: vertical front porch

Ports:
- `clk`, in, 1: pixel clock; one clock domain, no other clock.
- `rst`, in, 1: synchronous, active-high reset.
- `lcd_en`, in, 1: scan enable. 0 holds counters at 0 and outputs at reset values.
- `lcd_data_in`, in, 24: RGB888 from the generator, valid 1 cycle after the matching `cur_x`/`cur_y`.
- `cur_x`, out, 9: active-area column being requested.
- `cur_y`, out, 9: active-area row being requested.
- `frame_start`, out, 1: one-cycle pulse at counter position (0,0).
- `lcd_hs`, out, 1: hsync, active-low.
- `lcd_vs`, out, 1: vsync, active-low.
- `lcd_de`, out, 1: data enable, active-high.
- `lcd_rgb`, out, 24: pixel to the panel.

## Operation
- Totals: `H_TOTAL` = H_SYNC+H_BACK+H_DISP+H_FRONT (525); `V_TOTAL` likewise (286).
- Counters: `h_cnt` and `v_cnt` are 11-bit unsigned.
  - `h_cnt` increments every enabled cycle and wraps H_TOTAL−1 → 0.
  - On that wrap, `v_cnt` increments and wraps V_TOTAL−1 → 0.
  - A simultaneous wrap of both starts a new frame.
- Decode, per cycle, from the counter values:
  - `hs_n` = (h_cnt ≥ H_SYNC)
  - `vs_n` = (v_cnt ≥ V_SYNC)
  - `act` = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in the equivalent vertical window.
- Requests, registered:
  - When `act`, `cur_x` ← h_cnt−(H_SYNC+H_BACK) and `cur_y` ← v_cnt−(V_SYNC+V_BACK), truncated to 9 bits.
  - Otherwise both hold their last value; the generator output is ignored outside `act`.
- Output:
  - `lcd_rgb` ← `lcd_data_in` when the delayed `act` is 1, else 24'h000000.
  - `hs_n`, `vs_n` and `act` pass through a 2-stage delay line so that `lcd_hs`/`lcd_vs`/`lcd_de` align with `lcd_rgb`.
- `lcd_en` falling mid-frame:
  - Next cycle: counters go to 0, delay lines flush, and outputs return to reset values.
  - Rising `lcd_en` restarts the scan at (0,0) and produces a `frame_start` pulse.
- `rst` mid-frame behaves identically to `lcd_en`=0 for one cycle; the reset value wins over `lcd_en`.

## Timing
- Reset values: `cur_x`=0, `cur_y`=0, `frame_start`=0, `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0, counters 0, delay lines idle (hs=1, vs=1, act=0).
- Latency from counter state at cycle c:
  - `cur_x`/`cur_y` valid at c+1;
  - `lcd_data_in` for that request sampled at c+2;
  - `lcd_rgb`, `lcd_de`, `lcd_hs` and `lcd_vs` change at c+2.
- `frame_start` asserts in the cycle after the counters are (0,0): one cycle per frame, and also on the first enabled cycle after reset.
- First `lcd_de` of a frame occurs at counter time (H_SYNC+H_BACK, V_SYNC+V_BACK)+2.
- `lcd_de` is high for exactly H_DISP consecutive cycles per active line and low in blanking lines.
- No backpressure: the generator must respond with fixed 1-cycle latency.

## Configuration
- `LCD_TEST_PATTERN_EN`:
  - Defined: `lcd_data_in` is ignored. `lcd_rgb` shows 8 vertical colour bars, bar index = delayed `cur_x`[8:6], colours white, yellow, cyan, green, magenta, red, blue, black. Timing is unchanged.
  - Undefined: `lcd_rgb` is sourced from `lcd_data_in` as above.

## Structure
- Shared package `lcd_timing_pkg`:
  - default porch/sync/display constants;
  - the derived `H_TOTAL`/`V_TOTAL`;
  - the test-pattern colour constants.
- Sub-module `lcd_scan_counter`:
  - contents: `h_cnt`/`v_cnt` with wrap and enable;
  - outputs: counter values plus an `eof` strobe.
- The top level holds decode, request registers, delay lines and output registers.

## Test plan
- Reset then `lcd_en`=1 for 2 frames → `frame_start` pulses at cycles 1 and 1+150150; `lcd_hs` low 41 cycles of every 525; `lcd_vs` low 10 lines of 286.
- Generator model returns {cur_y[7:0], cur_x[8:1], 8'h5A} one cycle late → at every `lcd_de`=1 cycle, `lcd_rgb` matches the request from 2 cycles earlier; 480×272 high cycles per frame.
- `lcd_data_in`=24'hFFFFFF held constantly → `lcd_rgb`=0 whenever `lcd_de`=0.
- Drop `lcd_en` at line 100, pixel 200 for 5 cycles → outputs idle (hs=1, vs=1, de=0, rgb=0); on re-enable, scan restarts at (0,0) with a `frame_start` pulse.
- Assert `rst` for 1 cycle mid-active-line with `lcd_en`=1 → all outputs at reset values the next cycle; the subsequent frame is full-length.
- With `LCD_TEST_PATTERN_EN` defined → pixels 0–63 white (FFFFFF), 64–127 yellow (FFFF00), …, 448–479 black; `lcd_data_in` has no effect.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, types and test-pattern colours for the parallel-RGB LCD driver.
// The colour-bar source is used by lcd_rgb_driver when LCD_TEST_PATTERN_EN is defined.
package lcd_timing_pkg;

  localparam int H_SYNC_DEF  = 41;
  localparam int H_BACK_DEF  = 2;
  localparam int H_DISP_DEF  = 480;
  localparam int H_FRONT_DEF = 2;
  localparam int V_SYNC_DEF  = 10;
  localparam int V_BACK_DEF  = 2;
  localparam int V_DISP_DEF  = 272;
  localparam int V_FRONT_DEF = 2;

  localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_DISP_DEF + H_FRONT_DEF;
  localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_DISP_DEF + V_FRONT_DEF;

  typedef logic [10:0] cnt_t;
  typedef logic [8:0]  coord_t;
  typedef logic [23:0] rgb_t;

  // Per-cycle sync decode carried down the output delay line.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic act;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0};

  localparam rgb_t C_WHITE   = 24'hFFFFFF;
  localparam rgb_t C_YELLOW  = 24'hFFFF00;
  localparam rgb_t C_CYAN    = 24'h00FFFF;
  localparam rgb_t C_GREEN   = 24'h00FF00;
  localparam rgb_t C_MAGENTA = 24'hFF00FF;
  localparam rgb_t C_RED     = 24'hFF0000;
  localparam rgb_t C_BLUE    = 24'h0000FF;
  localparam rgb_t C_BLACK   = 24'h000000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_rgb_driver_if.sv
// Pixel bus of the LCD driver: request/colour exchange with the data generator
// and the registered panel-side signals.
interface lcd_rgb_driver_if;
  import lcd_timing_pkg::*;

  coord_t cur_x;
  coord_t cur_y;
  rgb_t   lcd_data_in;
  logic   frame_start;
  logic   lcd_hs;
  logic   lcd_vs;
  logic   lcd_de;
  rgb_t   lcd_rgb;

  modport master (
    output cur_x, cur_y, frame_start, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
    input  lcd_data_in
  );

  modport slave (
    input  cur_x, cur_y, frame_start, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
    output lcd_data_in
  );
endinterface

// File: rtl/lcd_scan_counter.sv
// Horizontal/vertical scan counters with wrap and enable; o_eof flags the last
// pixel of a frame. Disable or reset returns both counters to (0,0).
module lcd_scan_counter
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL_P = H_TOTAL,
  parameter int V_TOTAL_P = V_TOTAL
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output cnt_t o_h_cnt,
  output cnt_t o_v_cnt,
  output logic o_eof
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL_P - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL_P - 1);

  cnt_t r_h_cnt;
  cnt_t r_v_cnt;
  logic w_h_wrap;
  logic w_v_wrap;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 11'd1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 11'd1;
      end
    end
  end

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;
  assign o_eof   = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/lcd_rgb_driver.sv
// Parallel-RGB LCD timing driver: scan decode, pixel requests, 2-stage aligned outputs.
// Define LCD_TEST_PATTERN_EN to replace lcd_data_in with 8 vertical colour bars.
module lcd_rgb_driver
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_en,
  lcd_rgb_driver_if.master  bus
);

  localparam int H_TOTAL_L = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL_L = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam cnt_t H_SYNC_C = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_C = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_LO = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t H_ACT_HI = cnt_t'(H_SYNC + H_BACK + H_DISP);
  localparam cnt_t V_ACT_LO = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_ACT_HI = cnt_t'(V_SYNC + V_BACK + V_DISP);

  cnt_t   w_h_cnt;
  cnt_t   w_v_cnt;
  logic   w_eof;
  logic   w_clear;
  sync_t  w_sync;
  coord_t w_x_off;
  coord_t w_y_off;
  rgb_t   w_rgb_next;

  coord_t r_cur_x;
  coord_t r_cur_y;
  logic   r_sof_pend;
  logic   r_frame_start;
  sync_t  r_sync_d1;
  sync_t  r_sync_d2;
  rgb_t   r_rgb;

  lcd_scan_counter #(
    .H_TOTAL_P (H_TOTAL_L),
    .V_TOTAL_P (V_TOTAL_L)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .i_en    (lcd_en),
    .o_h_cnt (w_h_cnt),
    .o_v_cnt (w_v_cnt),
    .o_eof   (w_eof)
  );

  // Reset and disable collapse into one synchronous clear; reset therefore wins over lcd_en.
  assign w_clear = rst || !lcd_en;

  assign w_sync = '{
    hs_n: (w_h_cnt >= H_SYNC_C),
    vs_n: (w_v_cnt >= V_SYNC_C),
    act:  (w_h_cnt >= H_ACT_LO) && (w_h_cnt < H_ACT_HI) &&
          (w_v_cnt >= V_ACT_LO) && (w_v_cnt < V_ACT_HI)
  };

  assign w_x_off = coord_t'(w_h_cnt - H_ACT_LO);
  assign w_y_off = coord_t'(w_v_cnt - V_ACT_LO);

  // NOTE: w_rgb_next gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rgb_next = '0;
    if (r_sync_d1.act) begin
`ifdef LCD_TEST_PATTERN_EN
      w_rgb_next = bar_color(r_cur_x[8:6]);
`else
      w_rgb_next = bus.lcd_data_in;
`endif
    end
  end

  // r_sof_pend is high exactly while the counters sit at (0,0), so the pulse lands one cycle later.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_sof_pend    <= 1'b1;
      r_frame_start <= 1'b0;
      r_sync_d1     <= SYNC_IDLE;
      r_sync_d2     <= SYNC_IDLE;
      r_rgb         <= '0;
    end else begin
      r_frame_start <= r_sof_pend;
      r_sof_pend    <= w_eof;
      if (w_sync.act) begin
        r_cur_x <= w_x_off;
        r_cur_y <= w_y_off;
      end
      r_sync_d1 <= w_sync;
      r_sync_d2 <= r_sync_d1;
      r_rgb     <= w_rgb_next;
    end
  end

  assign bus.cur_x       = r_cur_x;
  assign bus.cur_y       = r_cur_y;
  assign bus.frame_start = r_frame_start;
  assign bus.lcd_hs      = r_sync_d2.hs_n;
  assign bus.lcd_vs      = r_sync_d2.vs_n;
  assign bus.lcd_de      = r_sync_d2.act;
  assign bus.lcd_rgb     = r_rgb;

endmodule
